// File: rtl/s2_mux_reg.sv
// s2_mux_reg: registered ACT-style logic cell with gated 4:1 select.
// Ports: clk, clr (async active-low clear), D00..D11 data, A0/B0/A1/B1 select gates, out.

// 2-input AND gate: forms select bit 0.
module s2_and2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

// 2-input OR gate: forms select bit 1.
module s2_or2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

// 4:1 multiplexer. The select applies to every bit of the data bus.
module s2_mux4 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d00_i,
    input  logic [WIDTH-1:0] d01_i,
    input  logic [WIDTH-1:0] d10_i,
    input  logic [WIDTH-1:0] d11_i,
    input  logic             s1_i,
    input  logic             s0_i,
    output logic [WIDTH-1:0] m_o
);
    always_comb begin
        m_o = d00_i;
        unique case ({s1_i, s0_i})
            2'b00: m_o = d00_i;
            2'b01: m_o = d01_i;
            2'b10: m_o = d10_i;
            2'b11: m_o = d11_i;
        endcase
    end
endmodule

// D flip-flop with asynchronous active-low clear.
module s2_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = d_i;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// Top: select gates, then mux, then flop.
// Each stage is a separate instance so it can be timed on its own.
module s2_mux_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] D00,
    input  logic [WIDTH-1:0] D01,
    input  logic [WIDTH-1:0] D10,
    input  logic [WIDTH-1:0] D11,
    input  logic             A0,
    input  logic             B0,
    input  logic             A1,
    input  logic             B1,
    output logic [WIDTH-1:0] out
);
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] m;

    s2_and2 u_sel0 (
        .a_i (A0),
        .b_i (B0),
        .y_o (s0)
    );

    s2_or2 u_sel1 (
        .a_i (A1),
        .b_i (B1),
        .y_o (s1)
    );

    s2_mux4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d00_i (D00),
        .d01_i (D01),
        .d10_i (D10),
        .d11_i (D11),
        .s1_i  (s1),
        .s0_i  (s0),
        .m_o   (m)
    );

    s2_dff #(
        .WIDTH (WIDTH)
    ) u_flop (
        .clk (clk),
        .clr (clr),
        .d_i (m),
        .q_o (out)
    );
endmodule

// File: tb/tb_s2_mux_reg.sv
// tb_s2_mux_reg: directed self-checking bench for s2_mux_reg (WIDTH=4).
// Ports: none; drives clk/clr/data/selects and checks out.
`timescale 1ns/1ps
module tb_s2_mux_reg;
    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic [W-1:0] D00;
    logic [W-1:0] D01;
    logic [W-1:0] D10;
    logic [W-1:0] D11;
    logic         A0;
    logic         B0;
    logic         A1;
    logic         B1;
    logic [W-1:0] out;

    int n_chk;
    int n_fail;

    s2_mux_reg #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .D00 (D00),
        .D01 (D01),
        .D10 (D10),
        .D11 (D11),
        .A0  (A0),
        .B0  (B0),
        .A1  (A1),
        .B1  (B1),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] exp);
        n_chk++;
        assert (out === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, out, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic a1, input logic b1,
                           input logic a0, input logic b0);
        A1 = a1;
        B1 = b1;
        A0 = a0;
        B0 = b0;
    endtask

    initial begin
        logic [3:0]   v;
        logic [1:0]   sidx;
        logic [W-1:0] exp;
        n_chk  = 0;
        n_fail = 0;
        clr = 1'b1;
        D00 = 4'd5;
        D01 = 4'd6;
        D10 = 4'd7;
        D11 = 4'd9;
        set_sel(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear before the first edge (first posedge is at 5 ns).
        #2;
        clr = 1'b0;
        #1;
        check("rst_immediate", 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", 4'd0);
        end

        // Release between edges; path 10 selected.
        D00 = 4'd0;
        D01 = 4'd1;
        D10 = 4'd1;
        D11 = 4'd0;
        set_sel(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        clr = 1'b1;
        #1;
        check("rel_no_edge", 4'd0);
        tick();
        check("path10", 4'd1);

        // Path 11: input change has no effect until the next edge.
        set_sel(1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        check("path11_pre", 4'd1);
        tick();
        check("path11", 4'd0);

        // Path 01 then 00 so both results differ from the prior value.
        set_sel(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        check("path01_pre", 4'd0);
        tick();
        check("path01", 4'd1);
        set_sel(1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        check("path00_pre", 4'd1);
        tick();
        check("path00", 4'd0);

        // Exhaustive select sweep with one-hot data.
        D00 = 4'b0001;
        D01 = 4'b0010;
        D10 = 4'b0100;
        D11 = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_sel(v[3], v[2], v[1], v[0]);
            sidx = {v[3] | v[2], v[1] & v[0]};
            exp  = 4'b0001 << sidx;
            tick();
            check($sformatf("sweep_%0d", i), exp);
        end

        // Asynchronous clear mid-stream.
        D00 = 4'd0;
        D01 = 4'd1;
        D10 = 4'd1;
        D11 = 4'd0;
        set_sel(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("mid_load", 4'd1);
        #1;
        clr = 1'b0;
        #0.5;
        check("mid_clr_fall", 4'd0);
        #1.5;
        clr = 1'b1;
        #1;
        check("mid_clr_after", 4'd0);
        tick();
        check("mid_reload", 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
